// File: rtl/cram_cfg_pkg.sv
// cram_cfg_pkg: loader state encoding and default chain geometry shared with the fabric top
package cram_cfg_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, FINISH} cfg_state_e;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_CHAIN_LEN = 240;
endpackage

// File: rtl/cfg_serializer.sv
// cfg_serializer: WORD_W-bit parallel-load shift register presenting its MSB first
module cfg_serializer
  import cram_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              dout
);
  logic [WORD_W-1:0] sreg;
  // zero-fill on shift so the line idles low once a word has been sent
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) sreg <= '0;
    else if (clr) sreg <= '0;
    else if (load) sreg <= word;
    else if (shift) sreg <= sreg << 1;
  assign dout = sreg[WORD_W-1];
endmodule

// File: rtl/cram_config_loader.sv
// cram_config_loader: serialises host A/B words into the CRAM chains; CRAM_READBACK_VERIFY_EN adds a two-pass readback check
module cram_config_loader
  import cram_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              verify,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_a,
  input  logic [WORD_W-1:0] word_b,
  output logic              config_en,
  output logic              en,
  output logic              config_data_inA,
  output logic              config_data_inB,
  input  logic              config_data_outA,
  input  logic              config_data_outB,
  output logic              busy,
  output logic              done,
  output logic              err
);
`ifdef CRAM_READBACK_VERIFY_EN
  localparam int CNT_W = $clog2(2 * CHAIN_LEN + 1);
`else
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
`endif
  localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN1 = CNT_W'(CHAIN_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

  if (CHAIN_LEN % WORD_W != 0 || CHAIN_LEN < WORD_W) begin : g_len_check
    $error("CHAIN_LEN must be a nonzero multiple of WORD_W");
  end

  cfg_state_e state, next;
  logic [CNT_W-1:0] cnt, cnt_nxt, target;
  logic [BW-1:0] bcnt;
  logic start_acc, load, shift;

  assign start_acc = state == IDLE && start && !abort;
  assign load = state == WAIT && word_valid && !abort;
  assign shift = state == SHIFT && !abort;
  assign cnt_nxt = cnt + 1'b1;
  assign word_ready = state == WAIT;
  assign busy = state != IDLE;

  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= next;

  // next state; abort wins over everything, including start
  always_comb begin
    next = state;
    if (abort) next = IDLE;
    else
      case (state)
        IDLE:    if (start) next = WAIT;
        WAIT:    if (word_valid) next = SHIFT;
        SHIFT:   if (bcnt == LAST_BIT) next = cnt_nxt == target ? FINISH : WAIT;
        default: next = IDLE;
      endcase
  end

  // strobes registered from next state so they line up with the serializer MSBs
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      en <= 1'b0;
      config_en <= 1'b0;
      done <= 1'b0;
    end else begin
      en <= next == SHIFT;
      config_en <= next == WAIT || next == SHIFT;
      done <= next == FINISH;
    end

  // total-bit and bit-in-word counters
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      cnt <= '0;
      bcnt <= '0;
    end else if (start_acc || abort) begin
      cnt <= '0;
      bcnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt_nxt;
      bcnt <= bcnt == LAST_BIT ? '0 : bcnt + 1'b1;
    end

  cfg_serializer #(.WORD_W(WORD_W)) u_ser_a (
    .clk(clk), .nrst(nrst), .clr(abort), .load(load), .shift(shift), .word(word_a), .dout(config_data_inA)
  );
  cfg_serializer #(.WORD_W(WORD_W)) u_ser_b (
    .clk(clk), .nrst(nrst), .clr(abort), .load(load), .shift(shift), .word(word_b), .dout(config_data_inB)
  );

`ifdef CRAM_READBACK_VERIFY_EN
  localparam logic [CNT_W-1:0] LEN2 = CNT_W'(2 * CHAIN_LEN);
  logic verify_q;
  // latch the mode at start; in pass 2 the tail must echo the bit being sent
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      verify_q <= 1'b0;
      err <= 1'b0;
    end else if (start_acc) begin
      verify_q <= verify;
      err <= 1'b0;
    end else if (shift && verify_q && cnt >= LEN1 &&
                 (config_data_inA != config_data_outA || config_data_inB != config_data_outB))
      err <= 1'b1;
  assign target = verify_q ? LEN2 : LEN1;
`else
  logic unused_inputs;
  assign unused_inputs = ^{verify, config_data_outA, config_data_outB};
  assign target = LEN1;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cram_config_loader.sv
// tb_cram_config_loader: randomized directed bench with behavioural 16-bit chains per bank
module tb_cram_config_loader;
  localparam int W = 8;
  localparam int L = 16;
  logic clk = 0, nrst = 0, start = 0, abort = 0, verify = 0, word_valid = 0;
  logic [W-1:0] word_a = 0, word_b = 0;
  logic word_ready, config_en, en, din_a, din_b, busy, done, err, dout_a, dout_b;
  logic [L-1:0] ch_a = 0, ch_b = 0;
  logic [W-1:0] wa [4], wb [4];
  int compared = 0, mismatched = 0;
  int en_total = 0, done_total = 0, bad_align = 0, err_at = -1;
  logic err_prev = 0;

  always #5 clk = ~clk;

  cram_config_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .verify(verify),
    .word_valid(word_valid), .word_ready(word_ready), .word_a(word_a), .word_b(word_b),
    .config_en(config_en), .en(en), .config_data_inA(din_a), .config_data_inB(din_b),
    .config_data_outA(dout_a), .config_data_outB(dout_b), .busy(busy), .done(done), .err(err)
  );

  assign dout_a = ch_a[L-1];
  assign dout_b = ch_b[L-1];

  // chains shift on the edge ending an en&&config_en cycle
  always @(posedge clk)
    if (en && config_en) begin
      ch_a <= {ch_a[L-2:0], din_a};
      ch_b <= {ch_b[L-2:0], din_b};
    end

  // event counters sampled mid-cycle
  always @(negedge clk) begin
    if (err && !err_prev) err_at = en_total;
    err_prev = err;
    if (en) en_total = en_total + 1;
    if (done) done_total = done_total + 1;
    if (en && !config_en) bad_align = bad_align + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (word_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (word_ready !== 1'b1) chk("ready_timeout", word_ready, 1);
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    if (stall > 0) begin
      word_valid = 0;
      wait_ready();
      repeat (stall) begin
        chk("stall_hold", {config_en, en}, 2'b10);
        @(negedge clk);
      end
    end
    word_valid = 1;
    word_a = a;
    word_b = b;
    wait_ready();
    @(negedge clk);
  endtask

  task automatic do_load(input int nw, input int stall, input logic ver, input logic poke,
                         output int en_d, output int done_d);
    int e0, d0, n;
    e0 = en_total;
    d0 = done_total;
    start = 1;
    verify = ver;
    @(negedge clk);
    start = 0;
    verify = 0;
    for (int i = 0; i < nw; i++) begin
      send_word(wa[i], wb[i], i == 0 ? 0 : stall);
      if (poke && i == 0) begin
        start = 1;
        @(negedge clk);
        start = 0;
      end
    end
    word_valid = 0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("strobes_at_done", {config_en, en}, 0);
    @(negedge clk);
    #1;
    chk("idle_after_done", {busy, config_en, done}, 0);
    en_d = en_total - e0;
    done_d = done_total - d0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) begin
      wa[i] = W'($urandom);
      wb[i] = W'($urandom);
    end
  endtask

  initial begin
    int ed, dd, d0, k, base;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {word_ready, config_en, en, din_a, din_b, busy, done, err}, 0);
    nrst = 1;
    @(negedge clk);
    #1;

    wa[0] = 8'hA5; wa[1] = 8'h3C; wb[0] = 8'h0F; wb[1] = 8'hF0;
    do_load(2, 0, 0, 0, ed, dd);
    chk("single_chain_a", ch_a, 16'hA53C);
    chk("single_chain_b", ch_b, 16'h0FF0);
    chk("single_en_cycles", ed, L);
    chk("single_done_pulses", dd, 1);

    for (int r = 0; r < 3; r++) begin
      rand_words();
      do_load(2, $urandom_range(0, 3), 0, 0, ed, dd);
      chk("rand_chain_a", ch_a, {wa[0], wa[1]});
      chk("rand_chain_b", ch_b, {wb[0], wb[1]});
      chk("rand_en_cycles", ed, L);
    end

    wa[0] = 8'hA5; wa[1] = 8'h3C; wb[0] = 8'h0F; wb[1] = 8'hF0;
    do_load(2, 5, 0, 0, ed, dd);
    chk("stall_chain_a", ch_a, 16'hA53C);
    chk("stall_chain_b", ch_b, 16'h0FF0);
    chk("stall_en_cycles", ed, L);

    d0 = done_total;
    start = 1;
    @(negedge clk);
    start = 0;
    send_word(8'hFF, 8'hFF, 0);
    word_valid = 0;
    chk("abort_in_shift", en, 1);
    repeat (2) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_strobes", {config_en, en, busy, word_ready}, 0);
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_done", done_total - d0, 0);
    rand_words();
    do_load(2, 1, 0, 0, ed, dd);
    chk("post_abort_chain_a", ch_a, {wa[0], wa[1]});
    chk("post_abort_chain_b", ch_b, {wb[0], wb[1]});

    start = 1;
    @(negedge clk);
    start = 0;
    send_word(8'h81, 8'h7E, 0);
    word_valid = 0;
    @(negedge clk);
    nrst = 0;
    #1;
    chk("mid_reset_outputs", {word_ready, config_en, en, din_a, din_b, busy, done, err}, 0);
    @(negedge clk);
    nrst = 1;
    #1;
    rand_words();
    do_load(2, 0, 0, 0, ed, dd);
    chk("post_reset_chain_a", ch_a, {wa[0], wa[1]});
    chk("post_reset_chain_b", ch_b, {wb[0], wb[1]});

    rand_words();
    do_load(2, 2, 0, 1, ed, dd);
    chk("busy_start_chain_a", ch_a, {wa[0], wa[1]});
    chk("busy_start_en_cycles", ed, L);
    chk("busy_start_done", dd, 1);

    d0 = done_total;
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("start_abort_idle", {busy, config_en, word_ready}, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("start_abort_quiet", {busy, done_total - d0}, 0);

`ifdef CRAM_READBACK_VERIFY_EN
    rand_words();
    wa[2] = wa[0]; wa[3] = wa[1]; wb[2] = wb[0]; wb[3] = wb[1];
    do_load(4, 0, 1, 0, ed, dd);
    chk("verify_clean_err", err, 0);
    chk("verify_en_cycles", ed, 2 * L);
    chk("verify_done", dd, 1);
    chk("verify_chain_a", ch_a, {wa[0], wa[1]});
    k = $urandom_range(0, L - 1);
    wb[2 + k / W] ^= 8'h80 >> (k % W);
    base = en_total;
    do_load(4, 1, 1, 0, ed, dd);
    chk("verify_bad_err_sticky", err, 1);
    chk("verify_bad_err_timing", err_at, base + L + k + 1);
    chk("verify_bad_done", dd, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("err_cleared_on_start", err, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
`else
    start = 1;
    verify = 1;
    @(negedge clk);
    start = 0;
    verify = 0;
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("no_verify_err", err, 0);
`endif

    chk("en_implies_config_en", bad_align, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
